heater_sequencer: RTL and testbench
===================================

// Module: heater_sequencer
// PURPOSE
//  Controller between the software GPIO enable/clear registers and the heater channel array.
//  - Staggers channel turn-on: at most one new channel every STEP_CYCLES, to limit inrush.
//  - Drops a channel on error, pulses its err_clear, and re-arms it.
//  - Latches a permanent fault after MAX_RETRY errors on a channel.
// PARAMETERS
//  Nchan       16    number of heater channels (>=2)
//  STEP_CYCLES 256   min cycles between successive turn-on grants (>=2)
//  CLR_CYCLES  4     err_clear pulse width in cycles (>=1)
//  MAX_RETRY   3     errors tolerated per channel before latching fault (>=1)
//  WDOG_CYCLES 2**20 watchdog timeout; used only with HEATER_SEQ_WDOG_EN
// PORTS
//  clk              in   1      single clock, all logic rising-edge
//  reset            in   1      synchronous, active-high
//  cmd_enable       in   Nchan  software-requested enables, level
//  fault_clear      in   Nchan  1-cycle pulse: clear fault[i] and retry count i
//  wdog_kick        in   1      1-cycle pulse: restart watchdog (ignored without macro)
//  heater_error     in   Nchan  per-channel error flags from heater array
//  heater_enable    out  Nchan  registered enables to heater array
//  heater_err_clear out  Nchan  registered clear pulses to heater array
//  fault            out  Nchan  latched permanent-fault mask
//  active_cnt       out  $clog2(Nchan+1)  popcount of heater_enable, registered
//  busy             out  1      ramp FSM not in R_IDLE, or error FSM not in E_IDLE
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs idle; all counters, retry counts, err_pend and rr pointer 0.
//  eligible[i] = cmd_enable[i] & ~heater_enable[i] & ~fault[i] & ~err_pend[i] & ~heater_error[i]
//  Ramp FSM:
//   - R_IDLE: if any eligible, grant first eligible at/after rr pointer (round-robin,
//     wrapping Nchan-1 -> 0). Set heater_enable[k] next cycle, rr=k+1 mod Nchan,
//     load step counter with STEP_CYCLES-1, go R_HOLD.
//   - R_HOLD: decrement counter; at 0 return to R_IDLE.
//   - Consecutive grants are exactly STEP_CYCLES cycles apart.
//  Disable: cmd_enable[i]=0 clears heater_enable[i] next cycle, in any state.
//   - An R_HOLD already in progress continues.
//  Error detect: heater_error[i] & heater_enable[i]
//   - Clear heater_enable[i] and set err_pend[i] next cycle.
//   - Overrides a same-cycle grant to i: grant suppressed, rr pointer unchanged.
//  Error FSM:
//   - E_IDLE: pick lowest-index err_pend channel k; go E_CLR.
//   - E_CLR: assert heater_err_clear[k] for CLR_CYCLES cycles; then go E_DONE.
//   - E_DONE (1 cycle): retry[k]++ (saturating at MAX_RETRY); clear err_pend[k].
//     If new retry[k]==MAX_RETRY, set fault[k]. Return to E_IDLE.
//   - Only one channel is serviced at a time; other err_pend bits wait.
//  Re-arm: after E_DONE, channel k becomes eligible again and goes through the ramp.
//  fault_clear[i]: clears fault[i] and retry[i] next cycle.
//   - Wins over a same-cycle E_DONE increment on i: result retry=0, fault=0.
//   - Does not abort an active E_CLR on i.
//  Counter width: retry counts are $clog2(MAX_RETRY+1) bits.
//  Error persisting after clear: heater_error still high keeps the channel ineligible; no re-grant until it falls.
//  Reset mid-operation: any cycle; everything returns to reset values next cycle, pulses truncated.
// CONFIGURATION
//  HEATER_SEQ_WDOG_EN defined:
//   - Watchdog counter reloads on wdog_kick or reset.
//   - On expiry (WDOG_CYCLES cycles with no kick): heater_enable forced to 0 next cycle.
//   - Ramp FSM is held in R_IDLE until the next wdog_kick.
//   - fault, retry counts and the error FSM are unaffected.
//  HEATER_SEQ_WDOG_EN undefined: no watchdog logic; wdog_kick ignored.
// TESTING
//  1 Ramp: STEP_CYCLES=8; cmd_enable 0->16'hFFFF
//    -> enables rise ch0,1,2,... exactly 8 cycles apart; active_cnt reaches 16 after 15*8+1 cycles.
//  2 Round-robin: after ch5 grant, cmd_enable={ch3,ch9}
//    -> ch9 granted before ch3.
//  3 Error/retry: pulse heater_error[2] while enabled
//    -> enable[2] low next cycle; err_clear[2] high exactly CLR_CYCLES=4 cycles; ch2 re-granted by ramp.
//  4 Fault: MAX_RETRY=3, three errors on ch7 -> fault[7]=1, ch7 never re-enabled;
//    fault_clear[7] -> fault[7]=0 next cycle, ch7 re-granted.
//  5 Simultaneous: errors on ch1 and ch4 in same cycle -> ch1 cleared first, then ch4;
//    grant-vs-error on the same channel -> no enable.
//  6 Watchdog (macro on, WDOG_CYCLES=100): no kick for 100 cycles -> all enables 0;
//    kick -> ramp restarts.

Source files
------------

// File: rtl/heater_sequencer_if.sv
// heater_sequencer_if: command, heater-array and status signals of the heater
// sequencer. The slave modport belongs to the sequencer. The master modport
// belongs to the software/heater-array side.
interface heater_sequencer_if #(
  parameter int unsigned Nchan = 16
);
  localparam int unsigned CW = $clog2(Nchan + 1);

  logic [Nchan-1:0] cmd_enable;
  logic [Nchan-1:0] fault_clear;
  logic             wdog_kick;
  logic [Nchan-1:0] heater_error;
  logic [Nchan-1:0] heater_enable;
  logic [Nchan-1:0] heater_err_clear;
  logic [Nchan-1:0] fault;
  logic [CW-1:0]    active_cnt;
  logic             busy;

  modport master (
    output cmd_enable, fault_clear, wdog_kick, heater_error,
    input  heater_enable, heater_err_clear, fault, active_cnt, busy
  );

  modport slave (
    input  cmd_enable, fault_clear, wdog_kick, heater_error,
    output heater_enable, heater_err_clear, fault, active_cnt, busy
  );
endinterface

// File: rtl/heater_sequencer.sv
// heater_sequencer: staggered channel turn-on (round-robin, one grant per
// STEP_CYCLES), error drop / err_clear pulse / re-arm per channel, and a
// permanent fault latch after MAX_RETRY errors.
// Optional watchdog: define HEATER_SEQ_WDOG_EN.
module heater_sequencer #(
  parameter int unsigned Nchan       = 16,
  parameter int unsigned STEP_CYCLES = 256,
  parameter int unsigned CLR_CYCLES  = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned WDOG_CYCLES = 2**20
) (
  input logic               clk,
  input logic               reset,
  heater_sequencer_if.slave bus
);
  localparam int unsigned IW = (Nchan > 1) ? $clog2(Nchan) : 1;
  localparam int unsigned CW = $clog2(Nchan + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned SW = $clog2(STEP_CYCLES);
  localparam int unsigned LW = $clog2(CLR_CYCLES + 1);

  typedef enum logic {R_IDLE, R_HOLD} ramp_state_e;
  typedef enum logic [1:0] {E_IDLE, E_CLR, E_DONE} err_state_e;

  ramp_state_e      rstate_q;
  err_state_e       estate_q;
  logic [SW-1:0]    step_q;
  logic [IW-1:0]    rr_q;
  logic [Nchan-1:0] en_q, en_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [Nchan-1:0] fault_q;
  logic [Nchan-1:0] pend_q;
  logic [Nchan-1:0] clr_q;
  logic [IW-1:0]    ek_q;
  logic [LW-1:0]    clr_cnt_q;
  logic [RW-1:0]    retry_q [Nchan];

  logic [Nchan-1:0] eligible, err_det, grant_oh;
  logic             grant_vld;
  logic [IW-1:0]    grant_idx;
  logic [IW:0]      scan_idx;
  logic             pend_vld;
  logic [IW-1:0]    pend_idx;
  logic [RW-1:0]    retry_cur, retry_inc;
  logic             wdog_block;

  // Eligibility, round-robin grant search and next enable vector
  always_comb begin
    eligible  = bus.cmd_enable & ~en_q & ~fault_q & ~pend_q & ~bus.heater_error;
    err_det   = bus.heater_error & en_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned j = 0; j < Nchan; j++) begin
      scan_idx = {1'b0, rr_q} + (IW+1)'(j);
      if (scan_idx >= (IW+1)'(Nchan)) scan_idx = scan_idx - (IW+1)'(Nchan);
      if (!grant_vld && eligible[scan_idx[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[IW-1:0];
      end
    end
    if (rstate_q != R_IDLE || wdog_block) grant_vld = 1'b0;
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
    // eligible excludes heater_error, so a same-cycle error can never be granted
    en_d = (en_q & bus.cmd_enable & ~err_det) | grant_oh;
    if (wdog_block) en_d = '0;
    cnt_d = '0;
    for (int unsigned i = 0; i < Nchan; i++) cnt_d = cnt_d + CW'(en_d[i]);
  end

  // Lowest pending channel and saturating retry increment for the serviced one
  always_comb begin
    pend_vld = 1'b0;
    pend_idx = '0;
    for (int unsigned i = 0; i < Nchan; i++) begin
      if (!pend_vld && pend_q[i]) begin
        pend_vld = 1'b1;
        pend_idx = IW'(i);
      end
    end
    retry_cur = retry_q[ek_q];
    retry_inc = (retry_cur >= RW'(MAX_RETRY)) ? RW'(MAX_RETRY) : retry_cur + RW'(1);
  end

  // Ramp FSM: grant, hold for STEP_CYCLES, registered enables and popcount
  always_ff @(posedge clk) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      step_q   <= '0;
      rr_q     <= '0;
      en_q     <= '0;
      cnt_q    <= '0;
    end else begin
      en_q  <= en_d;
      cnt_q <= cnt_d;
      case (rstate_q)
        R_IDLE: begin
          if (grant_vld) begin
            rr_q     <= (grant_idx == IW'(Nchan - 1)) ? '0 : grant_idx + IW'(1);
            step_q   <= SW'(STEP_CYCLES - 1);
            rstate_q <= R_HOLD;
          end
        end
        R_HOLD: begin
          // leaving on the 1->0 step makes the next grant exactly STEP_CYCLES later
          step_q <= step_q - SW'(1);
          if (step_q == SW'(1)) rstate_q <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
      if (wdog_block) rstate_q <= R_IDLE;
    end
  end

  // Error FSM: pending capture, err_clear pulse, retry count and fault latch
  always_ff @(posedge clk) begin
    if (reset) begin
      estate_q  <= E_IDLE;
      ek_q      <= '0;
      clr_cnt_q <= '0;
      clr_q     <= '0;
      pend_q    <= '0;
      fault_q   <= '0;
      for (int unsigned i = 0; i < Nchan; i++) retry_q[i] <= '0;
    end else begin
      pend_q <= pend_q | err_det;
      case (estate_q)
        E_IDLE: begin
          if (pend_vld) begin
            ek_q            <= pend_idx;
            clr_q           <= '0;
            clr_q[pend_idx] <= 1'b1;
            clr_cnt_q       <= LW'(CLR_CYCLES - 1);
            estate_q        <= E_CLR;
          end
        end
        E_CLR: begin
          if (clr_cnt_q == '0) begin
            clr_q    <= '0;
            estate_q <= E_DONE;
          end else begin
            clr_cnt_q <= clr_cnt_q - LW'(1);
          end
        end
        E_DONE: begin
          retry_q[ek_q] <= retry_inc;
          pend_q[ek_q]  <= 1'b0;
          if (retry_inc == RW'(MAX_RETRY)) fault_q[ek_q] <= 1'b1;
          estate_q <= E_IDLE;
        end
        default: estate_q <= E_IDLE;
      endcase
      // placed last so a same-cycle clear overrides the E_DONE update
      for (int unsigned i = 0; i < Nchan; i++) begin
        if (bus.fault_clear[i]) begin
          fault_q[i] <= 1'b0;
          retry_q[i] <= '0;
        end
      end
    end
  end

`ifdef HEATER_SEQ_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt_q;
  logic          wdog_exp_q;

  assign wdog_block = (wdog_exp_q || wdog_cnt_q == '0) && !bus.wdog_kick;

  // Watchdog: reload on kick/reset, latch expiry until the next kick
  always_ff @(posedge clk) begin
    if (reset || bus.wdog_kick) begin
      wdog_cnt_q <= WW'(WDOG_CYCLES - 1);
      wdog_exp_q <= 1'b0;
    end else if (wdog_cnt_q == '0) begin
      wdog_exp_q <= 1'b1;
    end else begin
      wdog_cnt_q <= wdog_cnt_q - WW'(1);
    end
  end
`else
  localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;
  logic unused_wdog_kick;
  assign unused_wdog_kick = bus.wdog_kick;
  assign wdog_block       = 1'b0;
`endif

  assign bus.heater_enable    = en_q;
  assign bus.heater_err_clear = clr_q;
  assign bus.fault            = fault_q;
  assign bus.active_cnt       = cnt_q;
  assign bus.busy             = (rstate_q != R_IDLE) || (estate_q != E_IDLE);
endmodule

// File: tb/tb_heater_sequencer.sv
// tb_heater_sequencer: scenario tasks for heater_sequencer; grant rising edges
// are checked against a queue of expected (channel, cycle) entries.
module tb_heater_sequencer;
  localparam int N    = 16;
  localparam int STEP = 8;
  localparam int CLR  = 4;
  localparam int MAXR = 3;
  localparam int WDOG = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  heater_sequencer_if #(.Nchan(N)) bus ();

  logic auto_kick  = 1'b1;
  logic auto_pulse = 1'b0;
  logic man_kick   = 1'b0;
  int   kick_div   = 0;
  assign bus.wdog_kick = auto_pulse | man_kick;

  heater_sequencer #(
    .Nchan(N), .STEP_CYCLES(STEP), .CLR_CYCLES(CLR), .MAX_RETRY(MAXR), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_ch[$];
  int exp_cyc[$];
  int mon_ch, mon_cyc;
  logic [N-1:0] prev_en = '0;

  // periodic background kick so the watchdog stays quiet outside its own test
  always @(negedge clk) begin
    kick_div   <= (kick_div == 39) ? 0 : kick_div + 1;
    auto_pulse <= auto_kick && (kick_div == 0);
  end

  // scoreboard: every enable rising edge must match the next expected grant
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < N; i++) begin
      if (bus.heater_enable[i] && !prev_en[i]) begin
        checks++;
        if (exp_ch.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: ch%0d rose at cycle %0d, expected no grant", i, cyc);
        end else begin
          mon_ch  = exp_ch.pop_front();
          mon_cyc = exp_cyc.pop_front();
          if (i !== mon_ch || cyc !== mon_cyc) begin
            errors++;
            $display("FAIL grant: got ch%0d at cycle %0d, expected ch%0d at cycle %0d",
                     i, cyc, mon_ch, mon_cyc);
          end
        end
      end
    end
    prev_en = bus.heater_enable;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int ch, input int c);
    exp_ch.push_back(ch);
    exp_cyc.push_back(c);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.cmd_enable   = '0;
    bus.fault_clear  = '0;
    bus.heater_error = '0;
    man_kick         = 1'b0;
    exp_ch.delete();
    exp_cyc.delete();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.heater_enable !== 16'h0) begin errors++; $display("FAIL reset_enable: got %h, expected 0000", bus.heater_enable); end
    checks++; if (bus.heater_err_clear !== 16'h0) begin errors++; $display("FAIL reset_err_clear: got %h, expected 0000", bus.heater_err_clear); end
    checks++; if (bus.fault !== 16'h0) begin errors++; $display("FAIL reset_fault: got %h, expected 0000", bus.fault); end
    checks++; if (bus.active_cnt !== 5'd0) begin errors++; $display("FAIL reset_active_cnt: got %0d, expected 0", bus.active_cnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_ramp();
    int s;
    do_reset();
    bus.cmd_enable = '1;
    s = cyc + 1;
    for (int i = 0; i < N; i++) push(i, s + STEP * i);
    repeat (STEP * (N - 1)) tick();
    checks++; if (bus.active_cnt !== 5'd15) begin errors++; $display("FAIL ramp_cnt15: got %0d, expected 15", bus.active_cnt); end
    tick();
    checks++; if (bus.active_cnt !== 5'd16) begin errors++; $display("FAIL ramp_cnt16: got %0d, expected 16", bus.active_cnt); end
    checks++; if (bus.heater_enable !== 16'hFFFF) begin errors++; $display("FAIL ramp_enable: got %h, expected ffff", bus.heater_enable); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ramp_busy: got %b, expected 1", bus.busy); end
    checks++; if (exp_ch.size() != 0) begin errors++; $display("FAIL ramp_missing: %0d grants not seen, expected 0", exp_ch.size()); end
  endtask

  task automatic test_round_robin();
    int s;
    do_reset();
    bus.cmd_enable = 16'h0030;
    s = cyc + 1;
    push(4, s); push(5, s + 8); push(9, s + 16); push(3, s + 24);
    repeat (9) tick();
    checks++; if (bus.heater_enable !== 16'h0030) begin errors++; $display("FAIL rr_first: got %h, expected 0030", bus.heater_enable); end
    bus.cmd_enable = 16'h0208;
    tick();
    checks++; if (bus.heater_enable !== 16'h0000) begin errors++; $display("FAIL rr_disable: got %h, expected 0000", bus.heater_enable); end
    repeat (16) tick();
    checks++; if (bus.heater_enable !== 16'h0208) begin errors++; $display("FAIL rr_final: got %h, expected 0208", bus.heater_enable); end
    checks++; if (exp_ch.size() != 0) begin errors++; $display("FAIL rr_missing: %0d grants not seen, expected 0", exp_ch.size()); end
  endtask

  task automatic test_error_retry();
    int s, e, n, first;
    do_reset();
    bus.cmd_enable = 16'h0004;
    s = cyc + 1;
    push(2, s);
    repeat (9) tick();
    bus.heater_error = 16'h0004;
    e = cyc + 1;
    push(2, e + 7);
    tick();
    bus.heater_error = '0;
    checks++; if (bus.heater_enable[2] !== 1'b0) begin errors++; $display("FAIL err_drop: enable[2]=%b, expected 0", bus.heater_enable[2]); end
    n = 0; first = -1;
    for (int k = 0; k < 8; k++) begin
      if (bus.heater_err_clear[2]) begin n++; if (first < 0) first = cyc; end
      tick();
    end
    checks++; if (n != CLR) begin errors++; $display("FAIL err_clear_width: got %0d cycles, expected %0d", n, CLR); end
    checks++; if (first != e + 1) begin errors++; $display("FAIL err_clear_start: got cycle %0d, expected %0d", first, e + 1); end
    checks++; if (bus.heater_enable !== 16'h0004) begin errors++; $display("FAIL err_rearm: got %h, expected 0004", bus.heater_enable); end
    checks++; if (exp_ch.size() != 0) begin errors++; $display("FAIL err_missing: %0d grants not seen, expected 0", exp_ch.size()); end
  endtask

  task automatic test_fault();
    int s, g, e, f;
    do_reset();
    bus.cmd_enable = 16'h0080;
    s = cyc + 1;
    g = s;
    e = s;
    push(7, s);
    for (int r = 0; r < MAXR; r++) begin
      repeat (g + 8 - cyc) tick();
      bus.heater_error = 16'h0080;
      e = cyc + 1;
      if (r < MAXR - 1) begin push(7, e + 7); g = e + 7; end
      tick();
      bus.heater_error = '0;
      checks++; if (bus.heater_enable[7] !== 1'b0) begin errors++; $display("FAIL fault_drop%0d: enable[7]=%b, expected 0", r, bus.heater_enable[7]); end
    end
    repeat (10) tick();
    checks++; if (bus.fault !== 16'h0080) begin errors++; $display("FAIL fault_latch: got %h, expected 0080", bus.fault); end
    checks++; if (bus.heater_enable !== 16'h0000) begin errors++; $display("FAIL fault_noenable: got %h, expected 0000", bus.heater_enable); end
    bus.fault_clear = 16'h0080;
    f = cyc + 1;
    push(7, f + 1);
    tick();
    bus.fault_clear = '0;
    checks++; if (bus.fault !== 16'h0000) begin errors++; $display("FAIL fault_clear: got %h, expected 0000", bus.fault); end
    tick();
    checks++; if (bus.heater_enable !== 16'h0080) begin errors++; $display("FAIL fault_regrant: got %h, expected 0080", bus.heater_enable); end
    checks++; if (exp_ch.size() != 0) begin errors++; $display("FAIL fault_missing: %0d grants not seen, expected 0", exp_ch.size()); end
  endtask

  task automatic test_simultaneous();
    int s, e, n1, n4, f1, f4;
    do_reset();
    bus.cmd_enable = 16'h0012;
    s = cyc + 1;
    push(1, s); push(4, s + 8);
    repeat (s + 17 - cyc) tick();
    bus.heater_error = 16'h0012;
    e = cyc + 1;
    push(1, e + 7); push(4, e + 15);
    tick();
    bus.heater_error = '0;
    checks++; if (bus.heater_enable !== 16'h0000) begin errors++; $display("FAIL sim_drop: got %h, expected 0000", bus.heater_enable); end
    n1 = 0; n4 = 0; f1 = -1; f4 = -1;
    for (int k = 0; k < 16; k++) begin
      if (bus.heater_err_clear[1]) begin n1++; if (f1 < 0) f1 = cyc; end
      if (bus.heater_err_clear[4]) begin n4++; if (f4 < 0) f4 = cyc; end
      tick();
    end
    checks++; if (f1 != e + 1 || n1 != CLR) begin errors++; $display("FAIL sim_clr1: start %0d width %0d, expected start %0d width %0d", f1, n1, e + 1, CLR); end
    checks++; if (f4 != e + 7 || n4 != CLR) begin errors++; $display("FAIL sim_clr4: start %0d width %0d, expected start %0d width %0d", f4, n4, e + 7, CLR); end
    checks++; if (bus.heater_enable !== 16'h0012) begin errors++; $display("FAIL sim_rearm: got %h, expected 0012", bus.heater_enable); end
    checks++; if (exp_ch.size() != 0) begin errors++; $display("FAIL sim_missing: %0d grants not seen, expected 0", exp_ch.size()); end
  endtask

  task automatic test_error_persist();
    do_reset();
    bus.cmd_enable   = 16'h0040;
    bus.heater_error = 16'h0040;
    repeat (6) tick();
    checks++; if (bus.heater_enable !== 16'h0000) begin errors++; $display("FAIL persist_noenable: got %h, expected 0000", bus.heater_enable); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL persist_busy: got %b, expected 0", bus.busy); end
    bus.heater_error = '0;
    push(6, cyc + 1);
    repeat (2) tick();
    checks++; if (bus.heater_enable !== 16'h0040) begin errors++; $display("FAIL persist_grant: got %h, expected 0040", bus.heater_enable); end
    checks++; if (exp_ch.size() != 0) begin errors++; $display("FAIL persist_missing: %0d grants not seen, expected 0", exp_ch.size()); end
  endtask

  task automatic test_reset_mid();
    int s;
    do_reset();
    bus.cmd_enable = '1;
    s = cyc + 1;
    push(0, s); push(1, s + 8);
    repeat (10) tick();
    bus.heater_error = 16'h0001;
    tick();
    bus.heater_error = '0;
    tick();
    checks++; if (bus.heater_err_clear !== 16'h0001) begin errors++; $display("FAIL mid_clr_active: got %h, expected 0001", bus.heater_err_clear); end
    checks++; if (exp_ch.size() != 0) begin errors++; $display("FAIL mid_missing: %0d grants not seen, expected 0", exp_ch.size()); end
    reset = 1'b1;
    bus.cmd_enable = '0;
    tick();
    checks++; if (bus.heater_enable !== 16'h0 || bus.heater_err_clear !== 16'h0) begin errors++; $display("FAIL mid_outputs: enable %h clear %h, expected 0000 0000", bus.heater_enable, bus.heater_err_clear); end
    checks++; if (bus.active_cnt !== 5'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_status: cnt %0d busy %b, expected 0 0", bus.active_cnt, bus.busy); end
    reset = 1'b0;
    tick();
  endtask

`ifdef HEATER_SEQ_WDOG_EN
  task automatic test_watchdog();
    int s;
    auto_kick = 1'b0;
    repeat (2) tick();
    do_reset();
    bus.cmd_enable = 16'h0001;
    s = cyc + 1;
    push(0, s);
    repeat (WDOG + 1) tick();
    checks++; if (bus.heater_enable !== 16'h0000) begin errors++; $display("FAIL wdog_expire: got %h, expected 0000", bus.heater_enable); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wdog_busy: got %b, expected 0", bus.busy); end
    man_kick = 1'b1;
    push(0, cyc + 1);
    tick();
    man_kick = 1'b0;
    tick();
    checks++; if (bus.heater_enable !== 16'h0001) begin errors++; $display("FAIL wdog_restart: got %h, expected 0001", bus.heater_enable); end
    checks++; if (exp_ch.size() != 0) begin errors++; $display("FAIL wdog_missing: %0d grants not seen, expected 0", exp_ch.size()); end
    auto_kick = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000 ns, expected finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_enable   = '0;
    bus.fault_clear  = '0;
    bus.heater_error = '0;
    tick();
    test_reset();
    test_ramp();
    test_round_robin();
    test_error_retry();
    test_fault();
    test_simultaneous();
    test_error_persist();
    test_reset_mid();
`ifdef HEATER_SEQ_WDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
